// File: rtl/matrix_scale_seq.sv
// -----------------------------------------------------------------------------
// matrix_scale_seq
//   Scales a ROWS x COLS matrix of signed Q(W-FRAC).FRAC elements, held in a
//   synchronous row-wide RAM, by one scalar. One row is read per cycle. All COLS
//   lanes are multiplied in parallel, and the scaled row is written back to the
//   same address two cycles later.
//
// Ports
//   clk, rst   rising-edge clock, synchronous active-high reset
//   start      run request, sampled only in IDLE; latches scalar
//   abort      cancels a run in progress, ignored in IDLE
//   scalar     signed scale factor
//   rd_en/rd_addr/rd_data   RAM read port (data valid one cycle after rd_en)
//   wr_en/wr_addr/wr_data   RAM write port
//   busy       run in progress (first read cycle through the done cycle)
//   done       one-cycle pulse after the last row has been written
//   dbg_state  current FSM state, for observation only
//
// Control semantics: start and abort are single-cycle requests, and there is
// no ready/ack. A request has effect only at the edge where it is sampled in a
// state that accepts it: start in IDLE, abort in RUN/DRAIN/DONE. When both are
// sampled in IDLE, start wins. Otherwise the request is dropped silently.
// -----------------------------------------------------------------------------
module matrix_scale_seq #(
  parameter int ROWS = 32,
  parameter int COLS = 10,
  parameter int W    = 32,
  parameter int FRAC = 24,
  parameter int AW   = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [W-1:0]        scalar,
  output logic                rd_en,
  output logic [AW-1:0]       rd_addr,
  input  logic [COLS*W-1:0]   rd_data,
  output logic                wr_en,
  output logic [AW-1:0]       wr_addr,
  output logic [COLS*W-1:0]   wr_data,
  output logic                busy,
  output logic                done,
  output logic [1:0]          dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);

  logic [1:0]         r_state;
  logic [W-1:0]       r_scalar;
  logic               r_rd_en;
  logic [AW-1:0]      r_rd_addr;
  // Stage 1: this cycle's rd_data belongs to the row at r_a1.
  logic               r_v1;
  logic [AW-1:0]      r_a1;
  logic               r_wr_en;
  logic [AW-1:0]      r_wr_addr;
  logic [COLS*W-1:0]  r_wr_data;
  logic               r_busy;
  logic               r_done;

  logic signed [2*W-1:0] w_prod [COLS];
  logic [COLS*W-1:0]     w_scaled;
  logic                  w_unused;

  // Per-lane multiply. The sign bit is kept from the top of the full product,
  // and the low W-1 result bits come from just above the fractional bits. The
  // bits in between are dropped, so overflow wraps and is not saturated.
  // Discarding the low FRAC bits truncates toward -inf.
  always_comb begin
    w_scaled = '0;
    w_unused = 1'b0;
    for (int i = 0; i < COLS; i++) begin
      w_prod[i] = $signed(r_scalar) * $signed(rd_data[(COLS-1-i)*W +: W]);
      w_scaled[(COLS-1-i)*W +: W] = {w_prod[i][2*W-1], w_prod[i][W+FRAC-2:FRAC]};
      w_unused = w_unused ^ (^w_prod[i][2*W-2:W+FRAC-1]) ^ (^w_prod[i][FRAC-1:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_scalar  <= '0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_v1      <= 1'b0;
      r_a1      <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;

      // Read -> multiply -> write pipeline. Addresses and data hold while idle.
      r_v1    <= r_rd_en;
      r_a1    <= r_rd_addr;
      r_wr_en <= r_v1;
      if (r_v1) begin
        r_wr_addr <= r_a1;
        r_wr_data <= w_scaled;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_RUN;
            r_scalar  <= scalar;
            r_busy    <= 1'b1;
            r_rd_en   <= 1'b1;
            r_rd_addr <= '0;
          end
        end
        S_RUN: begin
          if (r_rd_addr == LAST_ROW) begin
            r_rd_en <= 1'b0;
            r_state <= S_DRAIN;
          end else begin
            r_rd_addr <= r_rd_addr + AW'(1);
          end
        end
        S_DRAIN: begin
          if (r_wr_en && (r_wr_addr == LAST_ROW)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      // Abort overrides everything above. Rows still in the pipeline are
      // dropped, so no partial write escapes after this edge.
      if (abort && (r_state != S_IDLE)) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_rd_en <= 1'b0;
        r_v1    <= 1'b0;
        r_wr_en <= 1'b0;
        r_done  <= 1'b0;
      end
    end
  end

  assign rd_en     = r_rd_en;
  assign rd_addr   = r_rd_addr;
  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign busy      = r_busy;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_matrix_scale_seq.sv
// -----------------------------------------------------------------------------
// tb_matrix_scale_seq
//   Bench for matrix_scale_seq. It contains a behavioural row RAM, a
//   table-driven set of lane-arithmetic vectors, random-data runs, and
//   hand-written start/abort/reset sequences. Expected writes come from an
//   arithmetic model of the scaling rule and from the documented cycle timing,
//   with start accepted at cycle 0.
// -----------------------------------------------------------------------------
module tb_matrix_scale_seq;
  localparam int ROWS = 32;
  localparam int COLS = 10;
  localparam int W    = 32;
  localparam int FRAC = 24;
  localparam int AW   = 5;
  localparam int RW   = COLS * W;
  localparam int QW   = AW + RW;
  localparam int IDLE_CODE = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [W-1:0]  scalar = '0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [RW-1:0] rd_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [RW-1:0] wr_data;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;

  matrix_scale_seq #(.ROWS(ROWS), .COLS(COLS), .W(W), .FRAC(FRAC), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .scalar(scalar),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // ---------------- behavioural RAM (sync read, bench preload port) ----------------
  logic [RW-1:0] ram [ROWS];
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [RW-1:0] ld_data = '0;

  always @(posedge clk) begin
    if (rd_en) rd_data <= ram[rd_addr];
    if (wr_en) ram[wr_addr] <= wr_data;
    if (ld_en) ram[ld_addr] <= ld_data;
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [QW-1:0] exp_q[$];
  logic [RW-1:0] orig [ROWS];

  task automatic chk(input string name, input logic [QW-1:0] act, input logic [QW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference rule: full signed product, arithmetic shift right by FRAC
  // (floor), and the low W-1 bits of the result under the product's sign.
  function automatic logic [W-1:0] scale(input logic [W-1:0] s, input logic [W-1:0] e);
    longint p, q;
    logic [63:0] qv;
    p  = longint'($signed(s)) * longint'($signed(e));
    q  = p >>> FRAC;
    qv = q;
    return {(p < 0), qv[W-2:0]};
  endfunction

  function automatic logic [RW-1:0] scale_row(input logic [W-1:0] s, input logic [RW-1:0] row);
    logic [RW-1:0] res;
    res = '0;
    for (int i = 0; i < COLS; i++)
      res[(COLS-1-i)*W +: W] = scale(s, row[(COLS-1-i)*W +: W]);
    return res;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic fill_row(input int r, input logic [RW-1:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = AW'(r); ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic fill_random();
    logic [RW-1:0] d;
    for (int r = 0; r < ROWS; r++) begin
      for (int i = 0; i < COLS; i++) d[i*W +: W] = $urandom();
      fill_row(r, d);
    end
  endtask

  // One run with start accepted at cycle 0. An abort or reset is asserted
  // during cycle abort_at/rst_at (-1 = none). A restart with scalar=0 is
  // pulsed during cycle restart_at.
  task automatic run(input logic [W-1:0] s, input int abort_at, input int rst_at,
                     input int restart_at, input bit abort_with_start);
    int stop;
    bit exp_rd, exp_wr, exp_busy, exp_done;
    logic [QW-1:0] got;
    stop = ROWS + 100;
    if (abort_at >= 0) stop = abort_at;
    if (rst_at >= 0)   stop = rst_at;
    for (int r = 0; r < ROWS; r++) orig[r] = ram[r];
    exp_q.delete();
    for (int r = 0; r < ROWS; r++)
      if (3 + r <= stop) exp_q.push_back({AW'(r), scale_row(s, orig[r])});

    @(negedge clk);
    start = 1'b1; scalar = s; abort = abort_with_start;
    for (int c = 1; c <= ROWS + 5; c++) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0; rst = 1'b0;
      exp_rd   = (c <= ROWS) && (c <= stop);
      exp_wr   = (c >= 3) && (c <= ROWS + 2) && (c <= stop);
      exp_busy = (c <= ROWS + 3) && (c <= stop);
      exp_done = (c == ROWS + 3) && (stop > ROWS + 3);
      chk($sformatf("rd_en c%0d", c), QW'(rd_en), QW'(exp_rd));
      if (rd_en && exp_rd) chk($sformatf("rd_addr c%0d", c), QW'(rd_addr), QW'(c - 1));
      chk($sformatf("wr_en c%0d", c), QW'(wr_en), QW'(exp_wr));
      if (wr_en) begin
        got = {wr_addr, wr_data};
        if (exp_q.size() == 0) chk($sformatf("unexpected write c%0d", c), got, '0);
        else chk($sformatf("write c%0d", c), got, exp_q.pop_front());
      end
      if (rd_en && wr_en) begin
        n_cmp++;
        if (rd_addr == wr_addr) begin
          n_err++;
          $display("FAIL addr_clash c%0d: rd_addr %0d equals wr_addr %0d", c, rd_addr, wr_addr);
        end
      end
      chk($sformatf("busy c%0d", c), QW'(busy), QW'(exp_busy));
      chk($sformatf("done c%0d", c), QW'(done), QW'(exp_done));
      if (rst_at >= 0 && c == rst_at + 1) begin
        chk("rst wr_data", QW'(wr_data), '0);
        chk("rst rd_addr", QW'(rd_addr), '0);
        chk("rst wr_addr", QW'(wr_addr), '0);
        chk("rst state", QW'(dbg_state), QW'(IDLE_CODE));
      end
      if (c == abort_at) abort = 1'b1;
      if (c == rst_at) rst = 1'b1;
      if (c == restart_at) begin start = 1'b1; scalar = '0; end
    end
    chk("writes outstanding", QW'(exp_q.size()), '0);
    chk("idle state after run", QW'(dbg_state), QW'(IDLE_CODE));
    for (int r = 0; r < ROWS; r++)
      chk($sformatf("ram row %0d", r), QW'(ram[r]),
          QW'((3 + r <= stop) ? scale_row(s, orig[r]) : orig[r]));
  endtask

  // ---------------- lane arithmetic table ----------------
  typedef struct {
    logic [W-1:0] s;
    logic [W-1:0] e0;   // element 0 (MSB lane)
    logic [W-1:0] er;   // all other lanes
    logic [W-1:0] x0;
    logic [W-1:0] xr;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [RW-1:0] row;
    logic [W-1:0]  s;

    vecs[0] = '{32'h0080_0000, 32'h0200_0000, 32'h0200_0000, 32'h0100_0000, 32'h0100_0000};
    vecs[1] = '{32'hFF00_0000, 32'h0040_0000, 32'h0000_0000, 32'hFFC0_0000, 32'h0000_0000};
    vecs[2] = '{32'h0100_0000, 32'h1234_5678, 32'hFEDC_BA98, 32'h1234_5678, 32'hFEDC_BA98};
    vecs[3] = '{32'h0200_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE};
    vecs[4] = '{32'h0080_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF};
    vecs[5] = '{32'h1000_0000, 32'h1000_0000, 32'h0700_0000, 32'h0000_0000, 32'h7000_0000};
    vecs[6] = '{32'hFF00_0000, 32'hFF00_0000, 32'h8000_0000, 32'h0100_0000, 32'h0000_0000};

    // Reset check while rst is held high.
    repeat (3) @(negedge clk);
    chk("reset rd_en", QW'(rd_en), '0);
    chk("reset wr_en", QW'(wr_en), '0);
    chk("reset busy", QW'(busy), '0);
    chk("reset done", QW'(done), '0);
    chk("reset wr_data", QW'(wr_data), '0);
    chk("reset state", QW'(dbg_state), QW'(IDLE_CODE));
    rst = 1'b0;

    // Identity scale over random data, done at cycle ROWS+3.
    fill_random();
    run(32'h0100_0000, -1, -1, -1, 1'b0);

    // Table vectors: element 0 in the MSBs, distinct pattern in other lanes.
    foreach (vecs[k]) begin
      row = '0;
      for (int i = 0; i < COLS; i++) row[(COLS-1-i)*W +: W] = (i == 0) ? vecs[k].e0 : vecs[k].er;
      for (int r = 0; r < ROWS; r++) fill_row(r, row);
      run(vecs[k].s, -1, -1, -1, 1'b0);
      chk($sformatf("vec%0d lane0", k), QW'(ram[0][RW-1 -: W]), QW'(vecs[k].x0));
      chk($sformatf("vec%0d lane1", k), QW'(ram[ROWS-1][RW-W-1 -: W]), QW'(vecs[k].xr));
      chk($sformatf("vec%0d lastlane", k), QW'(ram[ROWS-1][W-1:0]), QW'(vecs[k].xr));
    end

    // Random scalars; start and abort together in IDLE still starts.
    fill_random();
    run($urandom(), -1, -1, -1, 1'b1);

    // Start re-pulsed at cycle 10 with scalar=0 is ignored.
    fill_random();
    s = $urandom_range(32'h0000_0000, 32'h7FFF_FFFF);
    run(s, -1, -1, 10, 1'b0);

    // Abort sampled at the end of cycle 8: the write already on the port in
    // cycle 8 (row 5) lands, and nothing is written from cycle 9.
    fill_random();
    run($urandom(), 8, -1, -1, 1'b0);
    run($urandom(), -1, -1, -1, 1'b0);

    // Reset at cycle 12, then a full run with a new scalar.
    fill_random();
    run($urandom(), -1, 12, -1, 1'b0);
    run($urandom(), -1, -1, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
